// File: rtl/ddr_app_pkg.sv
`default_nettype none
// ============================================================================
// Package : ddr_app_pkg
// Brief   : Shared command codes, beat addressing and FSM states for the
//           BRAM-backed DDR3 app-interface responder.
// Rev     : 1.0  initial release
// ============================================================================
package ddr_app_pkg;

    localparam logic [2:0] CMD_WRITE       = 3'd0;
    localparam logic [2:0] CMD_READ        = 3'd1;
    localparam int         BEAT_ADDR_STEP  = 8;
    localparam int         BEAT_ADDR_SHIFT = $clog2(BEAT_ADDR_STEP);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ddr_app_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : ddr_app_responder_if
// Brief     : DDR3 user/app command, write-data and read-data channels.
// Rev       : 1.0  initial release
// ============================================================================
interface ddr_app_responder_if #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256
);
    logic                    cmd_ready;
    logic [2:0]              cmd;
    logic                    cmd_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    wr_data_rdy;
    logic                    wr_data_en;
    logic                    wr_data_end;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_data_mask;
    logic                    rd_data_valid;
    logic                    rd_data_end;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    init_calib_complete;
    logic                    protocol_err;

    modport master (
        output cmd, cmd_en, addr, wr_data_en, wr_data_end, wr_data, wr_data_mask,
        input  cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end, rd_data,
               init_calib_complete, protocol_err
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data_en, wr_data_end, wr_data, wr_data_mask,
        output cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end, rd_data,
               init_calib_complete, protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/app_bram_bytewr.sv
`default_nettype none
// ============================================================================
// Module : app_bram_bytewr
// Brief  : Single-port inferred BRAM with per-byte write enables and a
//          registered read port that holds its value between reads.
// Rev    : 1.0  initial release
// ============================================================================
module app_bram_bytewr #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int c_NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array has no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ddr_app_responder.sv
`default_nettype none
// ============================================================================
// Module : ddr_app_responder
// Brief  : On-chip BRAM stand-in for the DDR3 memory interface app port.
// Rev    : 1.0  initial release
// ============================================================================
module ddr_app_responder
    import ddr_app_pkg::*;
#(
    parameter int ADDR_WIDTH  = 29,
    parameter int DATA_WIDTH  = 256,
    parameter int DEPTH_LOG2  = 10,
    parameter int BURST_LEN   = 4,
    parameter int RD_LATENCY  = 6,
    parameter int INIT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    ddr_app_responder_if.slave  app
);
    localparam int c_INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
    localparam int c_LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYCLES - 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_BEAT_W-1:0] c_BEATS     = c_BEAT_W'(BURST_LEN);
    localparam logic [c_LAT_W-1:0]  c_LAT_LAST  = c_LAT_W'(RD_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [c_INIT_W-1:0]     init_cnt_q, init_cnt_d;
    logic                    calib_q, calib_d;
    logic [DEPTH_LOG2-1:0]   base_q, base_d;
    logic [c_BEAT_W-1:0]     beat_q, beat_d;
    logic [c_LAT_W-1:0]      lat_q, lat_d;
    logic                    err_q, err_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_end_q, rd_end_d;

    logic                    w_mem_en;
    logic                    w_mem_we;
    logic [DEPTH_LOG2-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_addr_unused;

    assign w_addr_unused = ^{app.addr[ADDR_WIDTH-1:DEPTH_LOG2+BEAT_ADDR_SHIFT],
                             app.addr[BEAT_ADDR_SHIFT-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            calib_q    <= 1'b0;
            base_q     <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            calib_q    <= calib_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_end_q   <= rd_end_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        calib_d    = calib_q;
        base_d     = base_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_end_d   = 1'b0;
        w_mem_en   = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = base_q + DEPTH_LOG2'(beat_q);

        if (app.cmd_en && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
        if (app.wr_data_en && (state_q != WRITE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            INIT: begin
                if (init_cnt_q == c_INIT_LAST) begin
                    calib_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + c_INIT_W'(1);
                end
            end
            IDLE: begin
                if (app.cmd_en) begin
                    base_d = app.addr[DEPTH_LOG2+BEAT_ADDR_SHIFT-1:BEAT_ADDR_SHIFT];
                    beat_d = '0;
                    lat_d  = '0;
                    if (app.cmd == CMD_WRITE) begin
                        state_d = WRITE;
                    end else if (app.cmd == CMD_READ) begin
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (app.wr_data_en) begin
                    w_mem_en = 1'b1;
                    w_mem_we = 1'b1;
                    beat_d   = beat_q + c_BEAT_W'(1);
                    // Early end truncates; a missing end on the last beat is still accepted.
                    if (app.wr_data_end || (beat_q == c_LAST_BEAT)) begin
                        state_d = IDLE;
                        if (app.wr_data_end != (beat_q == c_LAST_BEAT)) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                if (lat_q != c_LAT_LAST) begin
                    lat_d = lat_q + c_LAT_W'(1);
                end else if (beat_q == c_BEATS) begin
                    state_d = IDLE;
                end else begin
                    w_mem_en   = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_end_d   = (beat_q == c_LAST_BEAT);
                    beat_d     = beat_q + c_BEAT_W'(1);
                end
            end
            default: state_d = INIT;
        endcase
    end

    // rst gates the port so a burst in flight cannot land one more beat.
    app_bram_bytewr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (DEPTH_LOG2)
    ) u_bram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_mem_en && !rst),
        .we_i    (w_mem_we),
        .be_i    (~app.wr_data_mask),
        .addr_i  (w_mem_addr),
        .wdata_i (app.wr_data),
        .rdata_o (w_rd_data)
    );

    assign app.cmd_ready           = (state_q == IDLE);
    assign app.wr_data_rdy         = (state_q == WRITE);
    assign app.rd_data_valid       = rd_valid_q;
    assign app.rd_data_end         = rd_end_q;
    assign app.rd_data             = w_rd_data;
    assign app.init_calib_complete = calib_q;
    assign app.protocol_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_app_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr_app_responder
// Brief  : Directed self-checking bench for ddr_app_responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ddr_app_responder;
    import ddr_app_pkg::*;

    localparam int AW = 29;
    localparam int DW = 256;
    typedef logic [DW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_app_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app ();

    ddr_app_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH_LOG2  (10),
        .BURST_LEN   (4),
        .RD_LATENCY  (6),
        .INIT_CYCLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .app (app)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t wd [4];
    beat_t rq [4];
    beat_t ex [4];

    task automatic check_eq(input string tag, input beat_t act, input beat_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic beat_t fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag, input bit poke);
        int cyc = 0;
        while (!app.init_calib_complete && cyc < 200) begin
            app.cmd_en = poke && (cyc == 5);
            tick();
            cyc++;
        end
        app.cmd_en = 1'b0;
        check_eq({tag, " init_cycles"}, DW'(cyc), DW'(64));
        check_eq({tag, " cmd_ready_at_calib"}, DW'(app.cmd_ready), DW'(1));
    endtask

    task automatic write_burst(input string tag, input logic [AW-1:0] a, input beat_t d [4],
                               input logic [31:0] m, input int last);
        app.cmd = CMD_WRITE; app.cmd_en = 1'b1; app.addr = a;
        tick();
        app.cmd_en = 1'b0;
        check_eq({tag, " wr_data_rdy"}, DW'(app.wr_data_rdy), DW'(1));
        for (int k = 0; k <= last; k++) begin
            app.wr_data_en = 1'b1; app.wr_data = d[k]; app.wr_data_mask = m;
            app.wr_data_end = (k == last);
            tick();
        end
        app.wr_data_en = 1'b0; app.wr_data_end = 1'b0; app.wr_data_mask = '0;
        check_eq({tag, " cmd_ready_after"}, DW'(app.cmd_ready), DW'(1));
    endtask

    task automatic read_burst(input string tag, input logic [AW-1:0] a, input bit stray,
                              output beat_t q [4]);
        int         lat = 0;
        logic [3:0] v   = '0;
        logic [3:0] e   = '0;
        app.cmd = CMD_READ; app.cmd_en = 1'b1; app.addr = a;
        tick();
        app.cmd_en = 1'b0;
        do begin
            if (stray && lat == 2) begin
                app.cmd = CMD_WRITE; app.cmd_en = 1'b1;
            end else begin
                app.cmd_en = 1'b0;
            end
            tick();
            lat++;
            if (stray && lat == 3) begin
                check_eq({tag, " stray_no_write"}, DW'(app.wr_data_rdy), DW'(0));
            end
        end while (!app.rd_data_valid && lat < 20);
        app.cmd_en = 1'b0;
        check_eq({tag, " latency"}, DW'(lat), DW'(6));
        for (int k = 0; k < 4; k++) begin
            q[k] = app.rd_data; v[k] = app.rd_data_valid; e[k] = app.rd_data_end;
            if (k < 3) tick();
        end
        check_eq({tag, " valid_beats"}, DW'(v), DW'(4'b1111));
        check_eq({tag, " end_pattern"}, DW'(e), DW'(4'b1000));
        tick();
        check_eq({tag, " valid_after"}, DW'(app.rd_data_valid), DW'(0));
        check_eq({tag, " rd_data_hold"}, app.rd_data, q[3]);
        check_eq({tag, " cmd_ready_after"}, DW'(app.cmd_ready), DW'(1));
    endtask

    task automatic check_beats(input string tag, input beat_t got [4], input beat_t exp [4],
                               input int n);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s beat%0d", tag, k), got[k], exp[k]);
        end
    endtask

    initial begin
        int lat;
        app.cmd = '0; app.cmd_en = 1'b0; app.addr = '0;
        app.wr_data_en = 1'b0; app.wr_data_end = 1'b0;
        app.wr_data = '0; app.wr_data_mask = '0;

        rst = 1'b1;
        tick(); tick();
        check_eq("rst cmd_ready", DW'(app.cmd_ready), DW'(0));
        check_eq("rst calib", DW'(app.init_calib_complete), DW'(0));
        check_eq("rst protocol_err", DW'(app.protocol_err), DW'(0));
        check_eq("rst rd_data_valid", DW'(app.rd_data_valid), DW'(0));
        check_eq("rst wr_data_rdy", DW'(app.wr_data_rdy), DW'(0));
        check_eq("rst rd_data", app.rd_data, '0);
        rst = 1'b0;
        wait_init("init0", 1'b0);

        // Plain write then read-back at 0x40 (index 8).
        wd = '{fill(8'h11), fill(8'h22), fill(8'h33), fill(8'h44)};
        write_burst("wr40", AW'('h40), wd, 32'h0, 3);
        read_burst("rd40", AW'('h40), 1'b0, rq);
        check_beats("rd40", rq, wd, 4);
        check_eq("rd40 protocol_err", DW'(app.protocol_err), DW'(0));

        // Masked write: bytes 0-3 keep the previous data.
        for (int k = 0; k < 4; k++) begin
            ex[k] = {{28{8'hAA}}, {4{8'(8'h11 * (k + 1))}}};
        end
        wd = '{fill(8'hAA), fill(8'hAA), fill(8'hAA), fill(8'hAA)};
        write_burst("wrmask", AW'('h40), wd, 32'h0000_000F, 3);
        read_burst("rdmask", AW'('h40), 1'b0, rq);
        check_beats("rdmask", rq, ex, 4);

        // Wrap from the top index back to 0.
        wd = '{fill(8'h51), fill(8'h52), fill(8'h53), fill(8'h54)};
        write_burst("wrwrap", AW'(1023 * 8), wd, 32'h0, 3);
        read_burst("rdtop", AW'(1023 * 8), 1'b0, rq);
        check_beats("rdtop", rq, wd, 4);
        read_burst("rdzero", AW'(0), 1'b0, rq);
        wd = '{fill(8'h52), fill(8'h53), fill(8'h54), fill(8'h00)};
        check_beats("rdzero", rq, wd, 3);
        check_eq("wrap protocol_err", DW'(app.protocol_err), DW'(0));

        // Stray write command during READ, with upper and low addr bits set.
        read_burst("rdstray", AW'('h0010_0045), 1'b1, rq);
        check_beats("rdstray", rq, ex, 4);
        check_eq("stray protocol_err", DW'(app.protocol_err), DW'(1));

        // Reset during a read burst.
        app.cmd = CMD_READ; app.cmd_en = 1'b1; app.addr = AW'('h40);
        tick();
        app.cmd_en = 1'b0;
        lat = 0;
        while (!app.rd_data_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("midrst latency", DW'(lat), DW'(6));
        tick();
        rst = 1'b1;
        tick();
        check_eq("midrst rd_data_valid", DW'(app.rd_data_valid), DW'(0));
        check_eq("midrst calib", DW'(app.init_calib_complete), DW'(0));
        check_eq("midrst protocol_err", DW'(app.protocol_err), DW'(0));
        rst = 1'b0;
        wait_init("init1", 1'b1);
        check_eq("init cmd_en protocol_err", DW'(app.protocol_err), DW'(1));
        read_burst("rdkeep", AW'('h40), 1'b0, rq);
        check_beats("rdkeep", rq, ex, 4);

        // Truncated write burst.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init("init2", 1'b0);
        check_eq("pre-trunc protocol_err", DW'(app.protocol_err), DW'(0));
        wd = '{fill(8'h61), fill(8'h62), fill(8'h63), fill(8'h64)};
        write_burst("wrtrunc", AW'('h200), wd, 32'h0, 1);
        check_eq("trunc protocol_err", DW'(app.protocol_err), DW'(1));
        check_eq("trunc wr_data_rdy", DW'(app.wr_data_rdy), DW'(0));
        read_burst("rdtrunc", AW'('h200), 1'b0, rq);
        check_beats("rdtrunc", rq, wd, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Single-clock, on-chip BRAM model of the DDR3 user/app command interface.
- Answers the frame-buffer DMA initiator (cmd/cmd_en/addr, wr_data handshake, rd_data return) exactly as the DDR3 memory interface does.
- Allows small-frame and simulation builds to run the video DMA path without external DDR3.
- Sits between the frame buffer's app port and nothing else; no pins.

Parameters:
- ADDR_WIDTH, 29: app address width. Units are 32-bit DQ words; one beat = 8 addresses.
- DATA_WIDTH, 256: beat width.
- DEPTH_LOG2, 10: log2 of BRAM depth in beats.
- BURST_LEN, 4: beats per command, 1..16.
- RD_LATENCY, 6: cycles from read-command accept to first rd_data_valid, ≥1.
- INIT_CYCLES, 64: cycles after reset release until init_calib_complete.

Ports:
- clk  in  1  app-side clock (dma clock domain).
- rst  in  1  synchronous, active-high reset.
- cmd_ready  out  1  responder can accept a command this cycle.
- cmd  in  3  0 = write, 1 = read, others illegal.
- cmd_en  in  1  command strobe.
- addr  in  ADDR_WIDTH  start address.
- wr_data_rdy  out  1  responder accepts write beats.
- wr_data_en  in  1  write beat valid.
- wr_data_end  in  1  last beat of the write burst.
- wr_data  in  DATA_WIDTH  write beat.
- wr_data_mask  in  DATA_WIDTH/8  per-byte mask; 1 = byte NOT written.
- rd_data_valid  out  1  read beat valid.
- rd_data_end  out  1  last read beat of the burst.
- rd_data  out  DATA_WIDTH  read beat.
- init_calib_complete  out  1  model ready.
- protocol_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: all outputs 0, state INIT, counters 0.
  - BRAM contents are not cleared.
  - Reset asserted mid-burst aborts the burst immediately; no further beats are written or returned.
- INIT: count INIT_CYCLES, then init_calib_complete=1 (stays 1 until rst) and go to IDLE.
- IDLE: cmd_ready=1.
  - Accept when cmd_en=1.
  - Latch base index = addr[DEPTH_LOG2+2:3]; addr[2:0] is ignored.
  - cmd=0 → WRITE. cmd=1 → READ.
  - Other cmd values: ignored, protocol_err=1, stay in IDLE.
- WRITE: cmd_ready=0, wr_data_rdy=1.
  - Each cycle with wr_data_en=1 writes beat n to index (base+n) mod 2^DEPTH_LOG2.
  - Bytes with mask bit 1 are left unchanged.
  - Exit to IDLE after beat BURST_LEN-1 is written, or on the first beat carrying wr_data_end.
  - wr_data_end before the last beat: burst truncated, protocol_err=1.
  - Last beat without wr_data_end: accepted, protocol_err=1.
  - cmd_ready rises the cycle after the final beat.
- READ: cmd_ready=0.
  - Wait RD_LATENCY-1 cycles after accept, so the first beat appears RD_LATENCY cycles after the accept edge.
  - Then drive BURST_LEN consecutive beats, rd_data_valid=1, from indices (base+n) mod depth.
  - BRAM read is registered, one cycle, and is included in the latency.
  - rd_data_end=1 on the last beat only.
  - rd_data holds its last value when rd_data_valid=0.
  - Return to IDLE the cycle after the last beat.
- Violations, each ignored and setting protocol_err:
  - cmd_en while cmd_ready=0.
  - wr_data_en outside WRITE.
  - cmd_en during INIT.
- Wrap-around: beat index arithmetic is modulo 2^DEPTH_LOG2; upper addr bits are ignored.
- Read-after-write to the same index in back-to-back commands returns the new data, since the write completes before the read is accepted.
- protocol_err clears only on rst.

Decomposition:
- Shared package ddr_app_pkg holds:
  - CMD_WRITE=3'd0, CMD_READ=3'd1.
  - BEAT_ADDR_STEP=8.
  - State enum {INIT, IDLE, WRITE, READ}.
- One sub-module, app_bram_bytewr: single-port BRAM with DATA_WIDTH/8 byte enables and registered read, inferred.

Test Plan:
- Reset, then count cycles → init_calib_complete rises exactly 64 cycles after rst deasserts; cmd_ready=1 the same cycle; cmd_en during INIT sets protocol_err.
- Write cmd at addr 0x40 with 4 beats 0x11..,0x22..,0x33..,0x44.. (end on beat 3); then read at 0x40 → rd_data_valid exactly 6 cycles after the read accept, 4 beats in order, rd_data_end on the 4th, protocol_err=0.
- Write at 0x40 with wr_data_mask=32'h0000_000F over 0xAA-filled data → bytes 0-3 keep their old values, others become 0xAA on readback.
- Write at addr (1023*8) with 4 beats → beats land at indices 1023,0,1,2; read at 0 returns beats 2..4.
- wr_data_end on beat 1 → burst truncated after 2 beats, protocol_err=1; cmd_en=1 during READ with cmd=0 → ignored (no state change), protocol_err=1.
- rst asserted on read beat 2 → rd_data_valid=0 on the next cycle, init_calib_complete=0, INIT reruns; prior written data still reads back after re-init.
